// File: rtl/vip_axi4_burst_addr_gen.sv
// AXI4 burst address generator: one command in, one beat per handshake out; illegal commands raise err_valid instead.
// Macro VIP_AXI4_BURST_ADDR_GEN_STRB_EN enables per-lane strobes, otherwise beat_strb is all-ones while beat_valid.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; the valid side holds its payload stable until then.
module vip_axi4_burst_addr_gen #(
   parameter int ADDR_WIDTH_P = 32,
   parameter int DATA_WIDTH_P = 64,
   parameter int LEN_WIDTH_P  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [ADDR_WIDTH_P-1:0]   cmd_addr,
   input  logic [LEN_WIDTH_P-1:0]    cmd_len,
   input  logic [2:0]                cmd_size,
   input  logic [1:0]                cmd_burst,
   output logic                      beat_valid,
   input  logic                      beat_ready,
   output logic [ADDR_WIDTH_P-1:0]   beat_addr,
   output logic [LEN_WIDTH_P-1:0]    beat_index,
   output logic                      beat_last,
   output logic [DATA_WIDTH_P/8-1:0] beat_strb,
   output logic                      err_valid,
   output logic [2:0]                err_code
);
   localparam int AW       = ADDR_WIDTH_P;
   localparam int LW       = LEN_WIDTH_P;
   localparam int SW       = DATA_WIDTH_P / 8;
   localparam int SIZE_MAX = $clog2(SW);

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] BURST_WRAP = 2'b10;
   localparam logic [1:0] BURST_RSVD = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ERR} state_t;

   state_t          state_q, state_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            beat_valid_q, beat_valid_d;
   logic [AW-1:0]   beat_addr_q, beat_addr_d;
   logic [LW-1:0]   beat_index_q, beat_index_d;
   logic            beat_last_q, beat_last_d;
   logic [SW-1:0]   beat_strb_q, beat_strb_d;
   logic            err_valid_q, err_valid_d;
   logic [2:0]      err_code_q, err_code_d;
   logic [LW-1:0]   len_q, len_d;
   logic [2:0]      size_q, size_d;
   logic [1:0]      burst_q, burst_d;
   logic [AW-1:0]   wrap_lower_q, wrap_lower_d;
   logic [AW-1:0]   wrap_end_q, wrap_end_d;

   logic [AW-1:0]   bytes_c, mask_c, aligned_c, len_ext_c, last_addr_c;
   logic [AW-1:0]   wrap_bytes_c, wrap_lower_c;
   logic            wrap_len_ok_c;
   logic [2:0]      chk_code_c;
   logic [AW-1:0]   step_c, incr_next_c, wrap_next_c, next_addr_c;
   logic [SW-1:0]   load_strb_c, next_strb_c;

   // Legality of the command currently on the cmd_* inputs; first failing check wins.
   always_comb begin
      bytes_c       = AW'(1) << cmd_size;
      mask_c        = bytes_c - AW'(1);
      aligned_c     = cmd_addr & ~mask_c;
      len_ext_c     = AW'(cmd_len);
      last_addr_c   = aligned_c + (len_ext_c << cmd_size);
      wrap_bytes_c  = (len_ext_c + AW'(1)) << cmd_size;
      wrap_lower_c  = cmd_addr & ~(wrap_bytes_c - AW'(1));
      wrap_len_ok_c = (len_ext_c == AW'(1)) || (len_ext_c == AW'(3)) ||
                      (len_ext_c == AW'(7)) || (len_ext_c == AW'(15));
      chk_code_c    = 3'd0;
      if (cmd_burst == BURST_RSVD)
         chk_code_c = 3'd1;
      else if (int'(cmd_size) > SIZE_MAX)
         chk_code_c = 3'd2;
      else if (cmd_burst == BURST_WRAP && !wrap_len_ok_c)
         chk_code_c = 3'd3;
      else if (cmd_burst == BURST_WRAP && (cmd_addr & mask_c) != '0)
         chk_code_c = 3'd4;
      else if (cmd_burst == BURST_INCR && last_addr_c[AW-1:12] != cmd_addr[AW-1:12])
         chk_code_c = 3'd5;
   end

   always_comb begin
      step_c      = AW'(1) << size_q;
      incr_next_c = (beat_addr_q & ~(step_c - AW'(1))) + step_c;
      wrap_next_c = beat_addr_q + step_c;
      if (wrap_next_c == wrap_end_q)
         wrap_next_c = wrap_lower_q;
      case (burst_q)
         BURST_INCR: next_addr_c = incr_next_c;
         BURST_WRAP: next_addr_c = wrap_next_c;
         default:    next_addr_c = beat_addr_q;
      endcase
   end

`ifdef VIP_AXI4_BURST_ADDR_GEN_STRB_EN
   // Lanes from the byte offset of addr up to the end of its size-aligned container.
   function automatic logic [SW-1:0] lane_strb(input logic [6:0] addr_lo, input logic [2:0] size);
      logic [SW-1:0] r;
      int lo, hi, b;
      b  = 1 << size;
      lo = int'(addr_lo) % SW;
      hi = (lo & ~(b - 1)) + b - 1;
      for (int i = 0; i < SW; i++)
         r[i] = (i >= lo) && (i <= hi);
      return r;
   endfunction

   always_comb begin
      load_strb_c = lane_strb(cmd_addr[6:0], cmd_size);
      next_strb_c = lane_strb(next_addr_c[6:0], size_q);
   end
`else
   always_comb begin
      load_strb_c = '1;
      next_strb_c = '1;
   end
`endif

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      beat_valid_d = beat_valid_q;
      beat_addr_d  = beat_addr_q;
      beat_index_d = beat_index_q;
      beat_last_d  = beat_last_q;
      beat_strb_d  = beat_strb_q;
      err_valid_d  = err_valid_q;
      err_code_d   = err_code_q;
      len_d        = len_q;
      size_d       = size_q;
      burst_d      = burst_q;
      wrap_lower_d = wrap_lower_q;
      wrap_end_d   = wrap_end_q;
      case (state_q)
         ST_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d  = 1'b0;
               len_d        = cmd_len;
               size_d       = cmd_size;
               burst_d      = cmd_burst;
               wrap_lower_d = wrap_lower_c;
               wrap_end_d   = wrap_lower_c + wrap_bytes_c;
               if (chk_code_c != 3'd0) begin
                  state_d     = ST_ERR;
                  err_valid_d = 1'b1;
                  err_code_d  = chk_code_c;
               end else begin
                  state_d      = ST_BURST;
                  beat_valid_d = 1'b1;
                  beat_addr_d  = cmd_addr;
                  beat_index_d = '0;
                  beat_last_d  = (cmd_len == '0);
                  beat_strb_d  = load_strb_c;
               end
            end
         end
         ST_BURST: begin
            if (beat_ready) begin
               if (beat_last_q) begin
                  state_d      = ST_IDLE;
                  beat_valid_d = 1'b0;
                  beat_last_d  = 1'b0;
                  beat_strb_d  = '0;
               end else begin
                  beat_addr_d  = next_addr_c;
                  beat_index_d = beat_index_q + LW'(1);
                  beat_last_d  = ((beat_index_q + LW'(1)) == len_q);
                  beat_strb_d  = next_strb_c;
               end
            end
         end
         ST_ERR: begin
            state_d     = ST_IDLE;
            err_valid_d = 1'b0;
            err_code_d  = 3'd0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cmd_ready_q  <= 1'b0;
         beat_valid_q <= 1'b0;
         beat_addr_q  <= '0;
         beat_index_q <= '0;
         beat_last_q  <= 1'b0;
         beat_strb_q  <= '0;
         err_valid_q  <= 1'b0;
         err_code_q   <= 3'd0;
         len_q        <= '0;
         size_q       <= 3'd0;
         burst_q      <= 2'b00;
         wrap_lower_q <= '0;
         wrap_end_q   <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         beat_valid_q <= beat_valid_d;
         beat_addr_q  <= beat_addr_d;
         beat_index_q <= beat_index_d;
         beat_last_q  <= beat_last_d;
         beat_strb_q  <= beat_strb_d;
         err_valid_q  <= err_valid_d;
         err_code_q   <= err_code_d;
         len_q        <= len_d;
         size_q       <= size_d;
         burst_q      <= burst_d;
         wrap_lower_q <= wrap_lower_d;
         wrap_end_q   <= wrap_end_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign beat_valid = beat_valid_q;
   assign beat_addr  = beat_addr_q;
   assign beat_index = beat_index_q;
   assign beat_last  = beat_last_q;
   assign beat_strb  = beat_strb_q;
   assign err_valid  = err_valid_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_vip_axi4_burst_addr_gen.sv
// Bench for vip_axi4_burst_addr_gen with default parameters (32-bit address, 64-bit data, 8-bit len).
// Honours VIP_AXI4_BURST_ADDR_GEN_STRB_EN when computing expected strobes.
module tb_vip_axi4_burst_addr_gen;
   localparam int W = 49;  // {addr[31:0], index[7:0], last, strb[7:0]}

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [1:0]  cmd_burst;
   logic        beat_valid, beat_ready, beat_last;
   logic [31:0] beat_addr;
   logic [7:0]  beat_index;
   logic [7:0]  beat_strb;
   logic        err_valid;
   logic [2:0]  err_code;

   logic        man_ready, rand_ready, bp_rand;
   int          checks = 0, errors = 0, cyc = 0;
   int          beat_cnt = 0, last_hs_cyc = 0;
   logic [31:0] last_beat_addr;
   logic [W-1:0] exp_q[$];
   logic [2:0]   err_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [2:0]  exp_err;
      int          exp_n;
      logic [31:0] exp_last;
   } vec_t;
   vec_t vecs[18];

   assign beat_ready = bp_rand ? rand_ready : man_ready;

   vip_axi4_burst_addr_gen dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
      .beat_index(beat_index), .beat_last(beat_last), .beat_strb(beat_strb),
      .err_valid(err_valid), .err_code(err_code)
   );

   // clock / reset-free cycle counter and random backpressure
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1 rand_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

`ifdef VIP_AXI4_BURST_ADDR_GEN_STRB_EN
   function automatic logic [7:0] model_strb(input logic [31:0] a, input logic [2:0] size);
      logic [7:0] ones, lo_mask, hi_mask;
      int lo, hi, b;
      ones    = 8'hFF;
      b       = 1 << size;
      lo      = int'(a[2:0]);
      hi      = (lo / b) * b + b - 1;
      lo_mask = ones << lo;
      hi_mask = ones >> (7 - hi);
      return lo_mask & hi_mask;
   endfunction
`endif

   function automatic logic [W-1:0] model_beat(input logic [31:0] addr, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst, input int n);
      logic [31:0] b, nn, a, wb, lower;
      logic [7:0]  s;
      b  = 32'd1 << size;
      nn = n;
      case (burst)
         2'b00:   a = addr;
         2'b01:   a = (n == 0) ? addr : (addr - (addr % b)) + nn * b;
         default: begin
            wb    = b * ({24'd0, len} + 32'd1);
            lower = addr - (addr % wb);
            a     = lower + ((addr - lower + nn * b) % wb);
         end
      endcase
`ifdef VIP_AXI4_BURST_ADDR_GEN_STRB_EN
      s = model_strb(a, size);
`else
      s = 8'hFF;
`endif
      return {a, nn[7:0], (nn == {24'd0, len}), s};
   endfunction

   function automatic logic [2:0] model_err(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] b, base, fin;
      b    = 32'd1 << size;
      base = addr - (addr % b);
      fin  = base + {24'd0, len} * b;
      if (burst == 2'b11) return 3'd1;
      if (b > 32'd8) return 3'd2;
      if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) return 3'd3;
      if (burst == 2'b10 && (addr % b) != 0) return 3'd4;
      if (burst == 2'b01 && fin[31:12] != addr[31:12]) return 3'd5;
      return 3'd0;
   endfunction

   // scoreboard: pop on every beat / error, check payload hold under backpressure
   logic         prev_stall = 1'b0;
   logic [48:0]  prev_beat;
   always @(negedge clk) begin
      if (!rst) begin
         if (beat_valid && beat_ready) begin
            if (exp_q.size() == 0) chk("beat_unexpected", {beat_addr, beat_index}, 0);
            else chk("beat", {beat_addr, beat_index, beat_last, beat_strb}, exp_q.pop_front());
            beat_cnt++;
            last_beat_addr = beat_addr;
            if (beat_last) last_hs_cyc = cyc;
         end
         if (err_valid) begin
            if (err_q.size() == 0) chk("err_unexpected", err_code, 0);
            else chk("err_code", err_code, err_q.pop_front());
            if (beat_valid) chk("err_with_beat", beat_valid, 0);
         end
         if (prev_stall) chk("hold", {beat_valid, beat_addr, beat_index, beat_last, beat_strb}, {1'b1, prev_beat});
      end
      prev_stall = !rst && beat_valid && !beat_ready;
      prev_beat  = {beat_addr, beat_index, beat_last, beat_strb};
   end

   task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [2:0] exp_err);
      logic ok;
      beat_cnt = 0;
      if (exp_err != 3'd0) err_q.push_back(exp_err);
      else for (int n = 0; n <= int'(len); n++) exp_q.push_back(model_beat(addr, len, size, burst, n));
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("cmd_accept", ok, 1);
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && err_q.size() == 0 && cmd_ready) begin done = 1'b1; break; end
      end
      chk("idle_timeout", done, 1);
   endtask

   initial begin
      vecs[0]  = '{32'h1000, 8'd3, 3'd2, 2'b01, 3'd0, 4, 32'h100C};
      vecs[1]  = '{32'h0034, 8'd3, 3'd2, 2'b10, 3'd0, 4, 32'h0030};
      vecs[2]  = '{32'h0034, 8'd2, 3'd2, 2'b10, 3'd3, 0, 32'h0};
      vecs[3]  = '{32'h0035, 8'd3, 3'd2, 2'b10, 3'd4, 0, 32'h0};
      vecs[4]  = '{32'h1002, 8'd1, 3'd2, 2'b01, 3'd0, 2, 32'h1004};
      vecs[5]  = '{32'h0FF8, 8'd1, 3'd3, 2'b01, 3'd5, 0, 32'h0};
      vecs[6]  = '{32'h0000, 8'd0, 3'd2, 2'b11, 3'd1, 0, 32'h0};
      vecs[7]  = '{32'h0100, 8'd0, 3'd4, 2'b01, 3'd2, 0, 32'h0};
      vecs[8]  = '{32'h0020, 8'd2, 3'd1, 2'b00, 3'd0, 3, 32'h0020};
      vecs[9]  = '{32'h0040, 8'd0, 3'd2, 2'b01, 3'd0, 1, 32'h0040};
      vecs[10] = '{32'h0FF8, 8'd0, 3'd3, 2'b01, 3'd0, 1, 32'h0FF8};
      vecs[11] = '{32'h1018, 8'd7, 3'd3, 2'b10, 3'd0, 8, 32'h1010};
      vecs[12] = '{32'h0006, 8'd1, 3'd0, 2'b10, 3'd0, 2, 32'h0007};
      vecs[13] = '{32'h0FFC, 8'd1, 3'd2, 2'b01, 3'd5, 0, 32'h0};
      vecs[14] = '{32'h0FFD, 8'd0, 3'd2, 2'b01, 3'd0, 1, 32'h0FFD};
      vecs[15] = '{32'h0000, 8'd0, 3'd7, 2'b11, 3'd1, 0, 32'h0};
      vecs[16] = '{32'h0000, 8'd2, 3'd7, 2'b10, 3'd2, 0, 32'h0};
      vecs[17] = '{32'h2003, 8'd5, 3'd0, 2'b01, 3'd0, 6, 32'h2008};

      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
      man_ready = 1'b1; bp_rand = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {cmd_ready, beat_valid, beat_addr, beat_index, beat_last, beat_strb, err_valid, err_code}, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ready_after_reset", cmd_ready, 1);

      // INCR burst with full throughput: ready returns two cycles after the last beat
      send_cmd(32'h1000, 8'd3, 3'd2, 2'b01, 3'd0);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      chk("ready_gap", cyc - last_hs_cyc, 2);
      chk("gap_nbeats", beat_cnt, 4);

      bp_rand = 1'b1;
      for (int i = 0; i < 18; i++) begin
         send_cmd(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].exp_err);
         wait_idle();
         chk($sformatf("vec%0d_nbeats", i), beat_cnt, vecs[i].exp_n);
         if (vecs[i].exp_n > 0) chk($sformatf("vec%0d_last_addr", i), last_beat_addr, vecs[i].exp_last);
      end
      bp_rand = 1'b0;

      // beat 1 held for three stalled cycles
      man_ready = 1'b0;
      send_cmd(32'h1000, 8'd3, 3'd2, 2'b01, 3'd0);
      man_ready = 1'b1;
      @(posedge clk); #1 man_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_beat1", {beat_valid, beat_addr, beat_index, beat_last}, {1'b1, 32'h1004, 8'd1, 1'b0});
      end
      man_ready = 1'b1;
      wait_idle();
      chk("bp_nbeats", beat_cnt, 4);

      // reset while beat 2 is pending
      man_ready = 1'b0;
      send_cmd(32'h1000, 8'd3, 3'd2, 2'b01, 3'd0);
      man_ready = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 man_ready = 1'b0;
      @(negedge clk);
      chk("rst_pre_beat2", {beat_valid, beat_addr, beat_index}, {1'b1, 32'h1008, 8'd2});
      @(posedge clk); #1 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("rst_pre_edge_beat2", beat_addr, 32'h1008);
      @(negedge clk);
      chk("rst_mid_burst", {cmd_ready, beat_valid, beat_addr, beat_index, beat_last, beat_strb, err_valid, err_code}, 0);
      @(posedge clk); #1 rst = 1'b0;
      man_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready_back", {cmd_ready, beat_valid}, 2'b10);

      bp_rand = 1'b1;
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a;
         logic [7:0]  l;
         logic [2:0]  s, e;
         logic [1:0]  b;
         a = $urandom_range(0, 32'h3FFF);
         l = 8'($urandom_range(0, 15));
         s = 3'($urandom_range(0, 4));
         b = 2'($urandom_range(0, 3));
         e = model_err(a, l, s, b);
         send_cmd(a, l, s, b, e);
         wait_idle();
         chk("rnd_nbeats", beat_cnt, (e != 3'd0) ? 0 : int'(l) + 1);
      end

      chk("queues_drained", exp_q.size() + err_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vip_axi4_burst_addr_gen.md
Name: vip_axi4_burst_addr_gen

Overview:
Parametrised AXI4 burst address and strobe generator for slave models and memory BFMs in the VIP.
- Accepts one burst command per handshake: start address, AxLEN, AxSIZE, AxBURST.
- Emits one beat per handshake with beat address, beat index and last flag.
- Supports FIXED, INCR and WRAP bursts.
- Detects illegal commands (reserved burst, oversize, bad wrap, 4 KB crossing) and reports them without emitting beats.

Parameters:
ADDR_WIDTH_P, 32, address width in bits (min 13).
DATA_WIDTH_P, 64, data bus width in bits; power of 2, 8..1024; STRB_WIDTH = DATA_WIDTH_P/8.
LEN_WIDTH_P, 8, AxLEN width; max burst = 2^LEN_WIDTH_P beats.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_addr  in  ADDR_WIDTH_P  start address
cmd_len  in  LEN_WIDTH_P  beats minus one
cmd_size  in  3  AxSIZE encoding, bytes = 2^cmd_size
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
beat_valid  out  1  beat valid
beat_ready  in  1  beat ready
beat_addr  out  ADDR_WIDTH_P  beat address
beat_index  out  LEN_WIDTH_P  beat number, 0-based
beat_last  out  1  final beat of burst
beat_strb  out  STRB_WIDTH  byte lanes of beat
err_valid  out  1  one-cycle error pulse
err_code  out  3  error cause

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: cmd_ready=0, beat_valid=0, beat_addr=0, beat_index=0, beat_last=0, beat_strb=0, err_valid=0, err_code=0, state=IDLE.
- cmd_ready rises the first cycle after rst deasserts.

States:
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the command and check legality.
  - Legal command -> BURST. Beat 0 is presented the next cycle (1-cycle latency).
  - Illegal command -> ERR.
- BURST: cmd_ready=0, beat_valid=1.
  - beat_addr, beat_index, beat_last, beat_strb are held stable while beat_ready=0.
  - On a handshake, advance one beat.
  - On the handshake with beat_last=1 -> IDLE. beat_valid drops and cmd_ready rises the following cycle (1 bubble; no back-to-back overlap).
- ERR: one cycle with err_valid=1 and err_code set, then -> IDLE. No beats are emitted for the command.

Error checks (first match wins):
- 1: cmd_burst=11 (reserved).
- 2: 2^cmd_size > STRB_WIDTH.
- 3: WRAP with cmd_len not in {1,3,7,15}.
- 4: WRAP with cmd_addr not aligned to the size.
- 5: INCR where aligned_addr + cmd_len*bytes crosses into a different 4 KB page than cmd_addr.

Address arithmetic:
- bytes = 1<<size; aligned = addr & ~(bytes-1).
- FIXED: every beat = cmd_addr.
- INCR: beat0 = cmd_addr (may be unaligned); beat n = aligned + n*bytes.
- WRAP: wrap_bytes = bytes*(len+1); lower = addr & ~(wrap_bytes-1); next = cur + bytes; if next == lower + wrap_bytes then next = lower.
- All arithmetic is done modulo 2^ADDR_WIDTH_P.
- beat_last = (beat_index == latched len). len=0 gives a single beat with beat_last=1.

Reset during BURST or ERR:
- Next cycle all outputs are at reset values.
- The pending burst is discarded.

Optional Feature:
Macro VIP_AXI4_BURST_ADDR_GEN_STRB_EN.
- Defined: beat_strb sets lanes from (beat_addr mod STRB_WIDTH) up to ((aligned beat address mod STRB_WIDTH) + bytes - 1).
  - Narrow transfers use the correct lane slice.
  - The unaligned first INCR/FIXED beat masks the bytes below beat_addr.
- Undefined: beat_strb is driven all-ones whenever beat_valid=1, and 0 otherwise. The port is still present.

Test Plan:
1. INCR addr 0x1000, len 3, size 4B -> beats 0x1000, 0x1004, 0x1008, 0x100C; index 0..3; beat_last only on the 4th; cmd_ready high again 2 cycles after the last handshake.
2. WRAP addr 0x0034, len 3, size 4B -> beats 0x34, 0x38, 0x3C, 0x30; WRAP len 2 -> err_code 3, no beats; WRAP addr 0x0035 -> err_code 4.
3. DATA_WIDTH_P=64, INCR addr 0x1002, len 1, size 4B -> beats 0x1002, 0x1004.
   - With STRB_EN: strb 0x0C, 0xF0.
   - Without STRB_EN: 0xFF, 0xFF.
4. INCR addr 0x0FF8, len 1, size 8B -> err_valid for 1 cycle with code 5 and no beat_valid; cmd_burst=11 -> code 1; size 16B on a 64-bit bus -> code 2.
5. Backpressure and reset:
   - Hold beat_ready low for 3 cycles on beat 1 of the test 1 command -> outputs stable, beat 1 still 0x1004 when ready rises.
   - Assert rst on beat 2 -> next cycle beat_valid=0; cmd_ready=1 the cycle after rst drops.
6. FIXED addr 0x20, len 2, size 2B -> three beats at 0x20, index 0, 1, 2, last on index 2; len 0 INCR -> single beat with beat_last=1.
